// File: rtl/xentry_pkg.sv
// Shared types for the dcache miss controller: L2 operation codes and controller states.
// DCACHE_FLUSH_ALL_EN adds the ST_WALK state used by the flush-all set walk.
package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd3
  } memory_operation_e;

`ifdef DCACHE_FLUSH_ALL_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_WALK  = 2'd3
  } dcache_ctrl_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LOAD  = 2'd2
  } dcache_ctrl_state_e;
`endif

endpackage

// File: rtl/dcache_word_counter.sv
// Wrapping up-counter with synchronous clear; o_last flags the terminal count so the
// owner can act on the final beat in the same cycle the counter wraps to zero.
module dcache_word_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == i_max);

endmodule

// File: rtl/dcache_line_ctrl.sv
// Dcache miss controller: write-back of dirty victims and line refill over an L2 handshake.
// Define DCACHE_FLUSH_ALL_EN to add the flush-all set walk (flush_all_req/done, set_override).
module dcache_line_ctrl
  import xentry_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned NUM_SETS       = 64,
  localparam int unsigned WIDX_W        = $clog2(WORDS_PER_LINE),
  localparam int unsigned SIDX_W        = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              hit,
  input  logic              dirty_miss,
  input  logic              clean_miss,
  input  logic              l2_req_ready,
  input  logic              l2_fetched_word_valid,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [WIDX_W-1:0] word_idx,
  output logic              flush_mode,
  output logic              load_mode,
  output logic              word_we,
  output logic              set_new_l2_block_address,
  output logic              clear_selected_dirty_bit,
  output logic              clear_selected_valid_bit,
  output logic              finish_new_line_install,
`ifdef DCACHE_FLUSH_ALL_EN
  input  logic              flush_all_req,
  output logic              flush_all_done,
  output logic [SIDX_W-1:0] set_override,
`endif
  output logic              stall
);

  dcache_ctrl_state_e r_state, w_state_d;

  logic              w_cnt_clr, w_cnt_inc, w_cnt_last;
  logic [WIDX_W-1:0] w_cnt;

  dcache_word_counter #(
    .W (WIDX_W)
  ) u_word_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .i_max   (WIDX_W'(WORDS_PER_LINE - 1)),
    .o_count (w_cnt),
    .o_last  (w_cnt_last)
  );

`ifdef DCACHE_FLUSH_ALL_EN
  // r_walk marks a flush issued by the set walk, so write-back returns to ST_WALK.
  logic              r_walk, w_walk_d;
  logic              w_set_clr, w_set_inc, w_set_last;
  logic [SIDX_W-1:0] w_set;

  dcache_word_counter #(
    .W (SIDX_W)
  ) u_set_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_set_clr),
    .i_inc   (w_set_inc),
    .i_max   (SIDX_W'(NUM_SETS - 1)),
    .o_count (w_set),
    .o_last  (w_set_last)
  );

  assign set_override = w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_walk <= 1'b0;
    end else begin
      r_walk <= w_walk_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d                = r_state;
    w_cnt_clr                = 1'b0;
    w_cnt_inc                = 1'b0;
    l2_req_valid             = 1'b0;
    l2_req_type              = LOAD;
    word_idx                 = '0;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    word_we                  = 1'b0;
    set_new_l2_block_address = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    stall                    = 1'b0;
`ifdef DCACHE_FLUSH_ALL_EN
    w_walk_d                 = r_walk;
    w_set_clr                = 1'b0;
    w_set_inc                = 1'b0;
    flush_all_done           = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef DCACHE_FLUSH_ALL_EN
        if (flush_all_req) begin
          w_set_clr = 1'b1;
          w_walk_d  = 1'b1;
          stall     = 1'b1;
          w_state_d = ST_WALK;
        end else
`endif
        // Hit wins over both miss flags; a lone request with no flag is a no-op.
        if (req_valid && !hit && (dirty_miss || clean_miss)) begin
          set_new_l2_block_address = 1'b1;
          stall                    = 1'b1;
          w_cnt_clr                = 1'b1;
          w_state_d                = dirty_miss ? ST_FLUSH : ST_LOAD;
        end
      end

      ST_FLUSH: begin
        flush_mode   = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_type  = STORE;
        word_idx     = w_cnt;
        stall        = 1'b1;
        if (l2_req_ready) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            clear_selected_dirty_bit = 1'b1;
            clear_selected_valid_bit = 1'b1;
`ifdef DCACHE_FLUSH_ALL_EN
            if (r_walk) begin
              w_state_d = ST_WALK;
            end else
`endif
            begin
              set_new_l2_block_address = 1'b1;
              w_state_d                = ST_LOAD;
            end
          end
        end
      end

      ST_LOAD: begin
        load_mode    = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_type  = LOAD;
        word_idx     = w_cnt;
        stall        = 1'b1;
        if (l2_fetched_word_valid) begin
          word_we   = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            finish_new_line_install = 1'b1;
            w_state_d               = ST_IDLE;
          end
        end
      end

`ifdef DCACHE_FLUSH_ALL_EN
      ST_WALK: begin
        // dirty_miss carries the overridden set's dirty flag; re-examined after write-back.
        stall = 1'b1;
        if (dirty_miss) begin
          set_new_l2_block_address = 1'b1;
          w_cnt_clr                = 1'b1;
          w_state_d                = ST_FLUSH;
        end else begin
          w_set_inc = 1'b1;
          if (w_set_last) begin
            flush_all_done = 1'b1;
            w_walk_d       = 1'b0;
            w_state_d      = ST_IDLE;
          end
        end
      end
`endif

      default: begin
        w_state_d                = ST_IDLE;
        l2_req_valid             = 1'bx;
        l2_req_type              = MO_UNKNOWN;
        word_idx                 = 'x;
        flush_mode               = 1'bx;
        load_mode                = 1'bx;
        word_we                  = 1'bx;
        set_new_l2_block_address = 1'bx;
        clear_selected_dirty_bit = 1'bx;
        clear_selected_valid_bit = 1'bx;
        finish_new_line_install  = 1'bx;
        stall                    = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Self-checking bench for dcache_line_ctrl: each miss is replayed as an expected per-cycle
// transaction script with random L2 wait states; the flush-all walk is exercised when enabled.
module tb_dcache_line_ctrl;
  import xentry_pkg::*;

`ifdef DCACHE_FLUSH_ALL_EN
  localparam int unsigned WPL = 8;
`else
  localparam int unsigned WPL = 4;
`endif
  localparam int unsigned NS   = 4;
  localparam int unsigned WIDX = $clog2(WPL);
  localparam int unsigned SIDX = $clog2(NS);

  logic clk, reset;
  logic req_valid, hit, dirty_miss, clean_miss, l2_req_ready, l2_fetched_word_valid;
  logic l2_req_valid, flush_mode, load_mode, word_we, set_new_l2_block_address;
  logic clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install, stall;
  memory_operation_e l2_req_type;
  logic [WIDX-1:0] word_idx;
`ifdef DCACHE_FLUSH_ALL_EN
  logic flush_all_req, flush_all_done;
  logic [SIDX-1:0] set_override;
  int unsigned n_store;
`endif

  int unsigned n_vec, n_err;

  dcache_line_ctrl #(
    .WORDS_PER_LINE (WPL),
    .NUM_SETS       (NS)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .req_valid                (req_valid),
    .hit                      (hit),
    .dirty_miss               (dirty_miss),
    .clean_miss               (clean_miss),
    .l2_req_ready             (l2_req_ready),
    .l2_fetched_word_valid    (l2_fetched_word_valid),
    .l2_req_valid             (l2_req_valid),
    .l2_req_type              (l2_req_type),
    .word_idx                 (word_idx),
    .flush_mode               (flush_mode),
    .load_mode                (load_mode),
    .word_we                  (word_we),
    .set_new_l2_block_address (set_new_l2_block_address),
    .clear_selected_dirty_bit (clear_selected_dirty_bit),
    .clear_selected_valid_bit (clear_selected_valid_bit),
    .finish_new_line_install  (finish_new_line_install),
`ifdef DCACHE_FLUSH_ALL_EN
    .flush_all_req            (flush_all_req),
    .flush_all_done           (flush_all_done),
    .set_override             (set_override),
`endif
    .stall                    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DCACHE_FLUSH_ALL_EN
  always @(posedge clk)
    if (!reset && l2_req_valid && l2_req_type == STORE && l2_req_ready) n_store++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output bundle: {valid, type, idx, flush, load, we, new_addr, clr_dirty, clr_valid, fin, stall}
  function automatic logic [31:0] obs();
    return 32'({l2_req_valid, l2_req_type, word_idx, flush_mode, load_mode, word_we,
                set_new_l2_block_address, clear_selected_dirty_bit, clear_selected_valid_bit,
                finish_new_line_install, stall});
  endfunction

  function automatic logic [31:0] ex(input bit v, input memory_operation_e t, input int idx,
                                     input bit fm, input bit lm, input bit we, input bit sn,
                                     input bit cd, input bit cv, input bit fin, input bit st);
    return 32'({v, t, WIDX'(idx), fm, lm, we, sn, cd, cv, fin, st});
  endfunction

  function automatic logic [31:0] e_idle();
    return ex(0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input bit rv, input bit h, input bit dm, input bit cm, input bit rdy,
                       input bit fv);
    req_valid = rv; hit = h; dirty_miss = dm; clean_miss = cm;
    l2_req_ready = rdy; l2_fetched_word_valid = fv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check(tag, obs(), exp);
    tick();
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // One miss from the idle request through replay; abort_at >= 0 resets on that load word.
  task automatic miss(input bit dirty, input int ww[WPL], input int wl[WPL], input int abort_at);
    drive(1, 0, dirty, dirty ? rb() : 1'b1, rb(), rb());
    step("miss_start", ex(0, LOAD, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    if (dirty) begin
      for (int w = 0; w < WPL; w++) begin
        for (int k = 0; k < ww[w]; k++) begin
          drive(1, rb(), rb(), rb(), 0, rb());
          step("wb_wait", ex(1, STORE, w, 1, 0, 0, 0, 0, 0, 0, 1));
        end
        drive(1, rb(), rb(), rb(), 1, rb());
        step("wb_accept", ex(1, STORE, w, 1, 0, 0, w == WPL - 1, w == WPL - 1, w == WPL - 1,
                             0, 1));
      end
    end
    for (int w = 0; w < WPL; w++) begin
      for (int k = 0; k < wl[w]; k++) begin
        drive(1, rb(), rb(), rb(), rb(), 0);
        step("fill_wait", ex(1, LOAD, w, 0, 1, 0, 0, 0, 0, 0, 1));
      end
      drive(1, rb(), rb(), rb(), rb(), 1);
      if (w == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step("abort_idle", e_idle());
        step("abort_quiet", e_idle());
        return;
      end
      step("fill_word", ex(1, LOAD, w, 0, 1, 1, 0, 0, 0, w == WPL - 1, 1));
    end
    drive(1, 1, 0, 0, 0, 0);
    step("replay_hit", e_idle());
  endtask

  int ww[WPL];
  int wl[WPL];

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef DCACHE_FLUSH_ALL_EN
    flush_all_req = 1'b0;
    n_store = 0;
`endif
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    step("reset_state", e_idle());
    reset = 1'b0;

    // L2 handshakes and lone requests while idle change nothing.
    drive(0, 0, 0, 0, 1, 1);
    repeat (3) step("idle_l2_junk", e_idle());
    drive(1, 0, 0, 0, 0, 1);
    step("req_no_flag", e_idle());
    drive(1, 1, 1, 1, 0, 0);
    step("hit_priority", e_idle());
    drive(0, 0, 0, 0, 0, 0);
    step("hit_stays_idle", e_idle());

    // Clean miss with returns on cycles 2,3,5,6 (one wait before the third word).
    for (int i = 0; i < WPL; i++) begin ww[i] = 0; wl[i] = 0; end
    wl[2] = 1;
    miss(0, ww, wl, -1);

    // Dirty miss with ready low for three cycles, then zero-wait accepts and refill.
    for (int i = 0; i < WPL; i++) begin ww[i] = 0; wl[i] = 0; end
    ww[0] = 3;
    miss(1, ww, wl, -1);

    // Reset during the third load word aborts silently; next miss restarts at word 0.
    for (int i = 0; i < WPL; i++) begin ww[i] = 0; wl[i] = 0; end
    miss(0, ww, wl, 2);
    miss(0, ww, wl, -1);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < WPL; i++) begin
        ww[i] = int'($urandom_range(0, 2));
        wl[i] = int'($urandom_range(0, 2));
      end
      miss(rb(), ww, wl, -1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        drive(rb(), 1, rb(), rb(), rb(), rb());
        if (!req_valid) begin
          dirty_miss = 1'b0;
          clean_miss = 1'b0;
        end
        step("idle_gap", e_idle());
      end
    end

`ifdef DCACHE_FLUSH_ALL_EN
    begin
      bit [NS-1:0] dirty_sets;
      dirty_sets = '0;
      dirty_sets[1] = 1'b1;
      dirty_sets[3] = 1'b1;
      n_store = 0;
      flush_all_req = 1'b1;
      drive(1, 0, 0, 1, 0, 0);
      step("walk_start", ex(0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      for (int s = 0; s < int'(NS); s++) begin
        while (dirty_sets[s]) begin
          drive(rb(), rb(), 1, rb(), rb(), rb());
          @(negedge clk);
          check("walk_set_dirty", 32'(set_override), 32'(s));
          check("walk_to_flush", obs(), ex(0, LOAD, 0, 0, 0, 0, 1, 0, 0, 0, 1));
          tick();
          for (int w = 0; w < WPL; w++) begin
            drive(rb(), rb(), rb(), rb(), 1, rb());
            @(negedge clk);
            check("walk_wb_set", 32'(set_override), 32'(s));
            check("walk_wb", obs(), ex(1, STORE, w, 1, 0, 0, 0, w == WPL - 1, w == WPL - 1,
                                       0, 1));
            tick();
          end
          dirty_sets[s] = 1'b0;
        end
        drive(rb(), rb(), 0, rb(), rb(), rb());
        @(negedge clk);
        check("walk_set", 32'(set_override), 32'(s));
        check("walk_done", 32'(flush_all_done), 32'(s == int'(NS) - 1));
        check("walk_advance", obs(), ex(0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
      end
      flush_all_req = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("walk_done_once", 32'(flush_all_done), 32'(0));
      step("walk_back_idle", e_idle());
      check("walk_store_words", 32'(n_store), 32'(2 * WPL));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
